// File: rtl/bomb_controller_pkg.sv
// Shared types and constants for the bomb controller: slot states, layer colours,
// tile width and the blast-cross test.
package bomb_pkg;
  localparam int TILE_W = 5;
  localparam logic [11:0] BOMB_RGB      = 12'h222;
  localparam logic [11:0] EXPLOSION_RGB = 12'hF80;

  typedef enum logic [1:0] {IDLE, ARMED, NOTIFY, EXPLODING} slot_state_e;

  // True when tile (px,py) lies on the plus-shaped blast centred on (sx,sy).
  // Differences are signed 6-bit so tiles near the map edge never wrap.
  function automatic logic in_cross(input logic [TILE_W-1:0] px, py, sx, sy,
                                    input int radius);
    logic signed [5:0] dx, dy;
    logic [5:0] ax, ay;
    dx = $signed({1'b0, px}) - $signed({1'b0, sx});
    dy = $signed({1'b0, py}) - $signed({1'b0, sy});
    ax = dx[5] ? 6'(-dx) : 6'(dx);
    ay = dy[5] ? 6'(-dy) : 6'(dy);
    return ((py == sy) && (int'(ax) <= radius)) || ((px == sx) && (int'(ay) <= radius));
  endfunction
endpackage

// File: rtl/bomb_controller_if.sv
// Blast notification channel from the bomb controller to the wall block.
interface bomb_controller_if;
  logic                       blast_valid;
  logic [bomb_pkg::TILE_W-1:0] blast_tile_x;
  logic [bomb_pkg::TILE_W-1:0] blast_tile_y;
  logic                       blast_ready;

  modport master (output blast_valid, blast_tile_x, blast_tile_y, input blast_ready);
  modport slave  (input blast_valid, blast_tile_x, blast_tile_y, output blast_ready);
endinterface

// File: rtl/bomb_controller_slot.sv
// One bomb slot: IDLE -> ARMED -> NOTIFY -> EXPLODING -> IDLE, with a shared
// fuse/explosion tick counter and the slot's tile position.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS    = 3,
  parameter int EXPLODE_TICKS = 1
) (
  input  logic              sys_clk,
  input  logic              Reset,
  input  logic              tick,
  input  logic              alloc_i,
  input  logic              accept_i,
  input  logic              chain_i,
  input  logic [TILE_W-1:0] tx_i,
  input  logic [TILE_W-1:0] ty_i,
  output slot_state_e       state_o,
  output logic [TILE_W-1:0] sx_o,
  output logic [TILE_W-1:0] sy_o
);
  localparam int MAXT = (FUSE_TICKS > EXPLODE_TICKS) ? FUSE_TICKS : EXPLODE_TICKS;
  localparam int TW   = $clog2(MAXT + 1);

  slot_state_e       state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [TILE_W-1:0] sx_q, sx_d, sy_q, sy_d;

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    case (state_q)
      IDLE: if (alloc_i) begin
        state_d = ARMED;
        tmr_d   = TW'(FUSE_TICKS);
        sx_d    = tx_i;
        sy_d    = ty_i;
      end
      ARMED: begin
        // chain_i is tied low unless chain reactions are built in
        if (chain_i) state_d = NOTIFY;
        else if (tick) begin
          if (tmr_q == TW'(1)) state_d = NOTIFY;
          else                 tmr_d   = tmr_q - 1'b1;
        end
      end
      NOTIFY: if (accept_i) begin
        state_d = EXPLODING;
        tmr_d   = TW'(EXPLODE_TICKS);
      end
      EXPLODING: if (tick) begin
        if (tmr_q == TW'(1)) state_d = IDLE;
        else                 tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;
  assign sx_o    = sx_q;
  assign sy_o    = sy_q;
endmodule

// File: rtl/bomb_controller.sv
// Bomb scheduler: slot allocation, blast arbitration, game-tick prescaler and
// bomb/explosion pixel layers. Optional BOMB_CHAIN_REACTION_EN lets blasts set off armed bombs.
module bomb_controller
  import bomb_pkg::*;
#(
  parameter int NUM_BOMBS     = 2,
  parameter int TICK_DIV      = 100000000,
  parameter int FUSE_TICKS    = 3,
  parameter int EXPLODE_TICKS = 1,
  parameter int TILE_SHIFT    = 5,
  parameter int BLAST_RADIUS  = 1
) (
  input  logic        sys_clk,
  input  logic        Reset,
  input  logic        place_req,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  bomb_controller_if.master blast,
  output logic        bomb_on,
  output logic [11:0] bomb_rgb,
  output logic        explosion_on,
  output logic [11:0] explosion_rgb,
  output logic        bomberman_hit,
  output logic [2:0]  active_bombs
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1;

  slot_state_e                         st [NUM_BOMBS];
  logic [NUM_BOMBS-1:0][TILE_W-1:0]    sx, sy;
  logic [NUM_BOMBS-1:0]                alloc, accept, chain;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick, place_q, place_rise;
  logic          lock_q, lock_d, gnt_valid;
  logic [IW-1:0] lock_idx_q, lock_idx_d, gnt_idx;
  logic          bomb_on_q, bomb_on_d, expl_on_q, expl_on_d, hit_q, hit_d;
  logic [2:0]    active_q, active_d;
  logic [10:0]   bx_sum, by_sum;
  logic [TILE_W-1:0] tx, ty, px, py;

  assign tick       = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d    = tick ? '0 : presc_q + 1'b1;
  assign place_rise = place_req & ~place_q;

  // Bomberman's target tile rounds his top-left corner to the nearest tile.
  assign bx_sum = {1'b0, b_x} + 11'(1 << (TILE_SHIFT - 1));
  assign by_sum = {1'b0, b_y} + 11'(1 << (TILE_SHIFT - 1));
  assign tx     = TILE_W'(bx_sum >> TILE_SHIFT);
  assign ty     = TILE_W'(by_sum >> TILE_SHIFT);
  assign px     = TILE_W'(v_x >> TILE_SHIFT);
  assign py     = TILE_W'(v_y >> TILE_SHIFT);

  for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
    bomb_slot #(.FUSE_TICKS(FUSE_TICKS), .EXPLODE_TICKS(EXPLODE_TICKS)) u_slot (
      .sys_clk  (sys_clk),
      .Reset    (Reset),
      .tick     (tick),
      .alloc_i  (alloc[g]),
      .accept_i (accept[g]),
      .chain_i  (chain[g]),
      .tx_i     (tx),
      .ty_i     (ty),
      .state_o  (st[g]),
      .sx_o     (sx[g]),
      .sy_o     (sy[g])
    );
  end

  // Allocation uses this cycle's states, so a slot freed now is only usable next cycle.
  always_comb begin
    logic occupied, found;
    alloc    = '0;
    occupied = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++)
      if (st[i] != IDLE && sx[i] == tx && sy[i] == ty) occupied = 1'b1;
    for (int i = 0; i < NUM_BOMBS; i++)
      if (!found && st[i] == IDLE) begin
        found    = 1'b1;
        alloc[i] = place_rise && !occupied;
      end
  end

  // Lowest-index NOTIFY slot wins; a stalled grant is locked so the tile holds.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_BOMBS; i++)
      if (!gnt_valid && st[i] == NOTIFY) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(i);
      end
    if (lock_q) begin
      gnt_valid = 1'b1;
      gnt_idx   = lock_idx_q;
    end
    lock_d     = gnt_valid && !blast.blast_ready;
    lock_idx_d = gnt_idx;
    for (int i = 0; i < NUM_BOMBS; i++)
      accept[i] = gnt_valid && blast.blast_ready && (gnt_idx == IW'(i));
  end

  assign blast.blast_valid  = gnt_valid;
  assign blast.blast_tile_x = gnt_valid ? sx[gnt_idx] : '0;
  assign blast.blast_tile_y = gnt_valid ? sy[gnt_idx] : '0;

  always_comb begin
    chain = '0;
`ifdef BOMB_CHAIN_REACTION_EN
    for (int i = 0; i < NUM_BOMBS; i++)
      for (int j = 0; j < NUM_BOMBS; j++)
        if (st[j] == EXPLODING && in_cross(sx[i], sy[i], sx[j], sy[j], BLAST_RADIUS))
          chain[i] = 1'b1;
`endif
  end

  always_comb begin
    bomb_on_d = 1'b0;
    expl_on_d = 1'b0;
    hit_d     = hit_q;
    active_d  = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (st[i] != IDLE) active_d = active_d + 1'b1;
      if ((st[i] == ARMED || st[i] == NOTIFY) && sx[i] == px && sy[i] == py) bomb_on_d = 1'b1;
      if (st[i] == EXPLODING) begin
        if (in_cross(px, py, sx[i], sy[i], BLAST_RADIUS)) expl_on_d = 1'b1;
        if (in_cross(tx, ty, sx[i], sy[i], BLAST_RADIUS)) hit_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      presc_q    <= '0;
      place_q    <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      bomb_on_q  <= 1'b0;
      expl_on_q  <= 1'b0;
      hit_q      <= 1'b0;
      active_q   <= '0;
    end else begin
      presc_q    <= presc_d;
      place_q    <= place_req;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      bomb_on_q  <= bomb_on_d;
      expl_on_q  <= expl_on_d;
      hit_q      <= hit_d;
      active_q   <= active_d;
    end
  end

  assign bomb_on       = bomb_on_q;
  assign explosion_on  = expl_on_q;
  assign bomberman_hit = hit_q;
  assign active_bombs  = active_q;
  assign bomb_rgb      = BOMB_RGB;
  assign explosion_rgb = EXPLOSION_RGB;
endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller; blast notifications are checked by a
// scoreboard monitor against tiles queued when bombs are placed.
module tb_bomb_controller;
  logic       sys_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       place_req = 1'b0;
  logic [9:0] b_x = '0, b_y = '0, v_x = '0, v_y = '0;
  logic       bomb_on, explosion_on, bomberman_hit;
  logic [11:0] bomb_rgb, explosion_rgb;
  logic [2:0] active_bombs;

  bomb_controller_if bif();

  bomb_controller #(
    .NUM_BOMBS(2), .TICK_DIV(10), .FUSE_TICKS(3), .EXPLODE_TICKS(1),
    .TILE_SHIFT(5), .BLAST_RADIUS(1)
  ) dut (
    .sys_clk(sys_clk), .Reset(Reset), .place_req(place_req),
    .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
    .blast(bif),
    .bomb_on(bomb_on), .bomb_rgb(bomb_rgb),
    .explosion_on(explosion_on), .explosion_rgb(explosion_rgb),
    .bomberman_hit(bomberman_hit), .active_bombs(active_bombs)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0, fails = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic place(input logic [9:0] x, input logic [9:0] y);
    b_x = x; b_y = y; place_req = 1'b1;
    cyc(1);
    place_req = 1'b0;
    cyc(1);
  endtask

  task automatic wait_hs(input string name, input int max, output int n);
    n = 0;
    while (!(bif.blast_valid && bif.blast_ready) && n < max) begin
      cyc(1);
      n++;
    end
    if (n >= max) timeout(name);
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!bif.blast_valid && n < max) begin cyc(1); n++; end
    if (n >= max) timeout(name);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (active_bombs != 3'd0 && n < max) begin cyc(1); n++; end
    if (n >= max) timeout(name);
  endtask

  task automatic check_pix(input string name, input logic [9:0] x, input logic [9:0] y,
                           input logic e_expl, input logic e_bomb);
    v_x = x; v_y = y;
    cyc(1);
    chk({name, "_expl"}, explosion_on, e_expl);
    chk({name, "_bomb"}, bomb_on, e_bomb);
  endtask

  // Scoreboard monitor: samples just after the negedge, once the bench has driven.
  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(negedge sys_clk);
      #2;
      if (!Reset && bif.blast_valid && bif.blast_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL blast_unexpected: got tile (%0d,%0d) expected none",
                   bif.blast_tile_x, bif.blast_tile_y);
        end else begin
          e = exp_q.pop_front();
          if ({bif.blast_tile_x, bif.blast_tile_y} !== e) begin
            fails++;
            $display("FAIL blast_tile: got (%0d,%0d) expected (%0d,%0d)",
                     bif.blast_tile_x, bif.blast_tile_y, e[9:5], e[4:0]);
          end
        end
      end
    end
  end

  initial begin
    int n;
    bif.blast_ready = 1'b1;
    cyc(2);
    chk("rst_valid", bif.blast_valid, 0);
    chk("rst_tile", {bif.blast_tile_x, bif.blast_tile_y}, 0);
    chk("rst_bomb_on", bomb_on, 0);
    chk("rst_expl_on", explosion_on, 0);
    chk("rst_hit", bomberman_hit, 0);
    chk("rst_active", active_bombs, 0);
    chk("rst_bomb_rgb", bomb_rgb, 12'h222);
    chk("rst_expl_rgb", explosion_rgb, 12'hF80);
    Reset = 1'b0;
    cyc(1);

    // Single bomb at tile (2,2), button held for three cycles
    v_x = 64; v_y = 64;
    b_x = 64; b_y = 64; place_req = 1'b1;
    exp_q.push_back({5'd2, 5'd2});
    cyc(3);
    place_req = 1'b0;
    chk("single_active", active_bombs, 1);
    chk("single_bomb_on", bomb_on, 1);
    b_x = 96;
    cyc(1);
    chk("hit_before", bomberman_hit, 0);
    wait_hs("single_blast", 40, n);
    tests++;
    if (n + 4 < 20 || n + 4 > 32) begin
      fails++;
      $display("FAIL single_latency: got %0d cycles expected 20..32", n + 4);
    end
    cyc(1);
    check_pix("pix_96_64", 96, 64, 1'b1, 1'b0);
    check_pix("pix_64_32", 64, 32, 1'b1, 1'b0);
    check_pix("pix_128_64", 128, 64, 1'b0, 1'b0);
    check_pix("pix_64_64", 64, 64, 1'b1, 1'b0);
    chk("hit_during", bomberman_hit, 1);
    wait_idle("single_idle", 30);
    chk("single_active_end", active_bombs, 0);
    chk("hit_sticky", bomberman_hit, 1);

    // Same tile twice: second request rejected
    place(64, 64);
    exp_q.push_back({5'd2, 5'd2});
    place(64, 64);
    cyc(2);
    chk("same_tile_active", active_bombs, 1);
    wait_hs("same_tile_blast", 40, n);
    wait_idle("same_tile_idle", 30);

    // Capacity plus stalled handshake
    bif.blast_ready = 1'b0;
    place(32, 32);
    place(96, 32);
    place(160, 32);
    exp_q.push_back({5'd1, 5'd1});
    exp_q.push_back({5'd3, 5'd1});
    cyc(2);
    chk("capacity_active", active_bombs, 2);
    wait_valid("stall_valid", 40);
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      chk("stall_valid_hold", bif.blast_valid, 1);
      chk("stall_tile_hold", {bif.blast_tile_x, bif.blast_tile_y}, {5'd1, 5'd1});
    end
    bif.blast_ready = 1'b1;
    cyc(1);
    chk("second_valid", bif.blast_valid, 1);
    chk("second_tile", {bif.blast_tile_x, bif.blast_tile_y}, {5'd3, 5'd1});
    wait_idle("capacity_idle", 40);

    // Reset while a slot explodes; neighbour at (3,2) tests chain reaction
    v_x = 64; v_y = 64;
    place(64, 64);
    exp_q.push_back({5'd2, 5'd2});
    cyc(12);
    place(96, 64);
`ifdef BOMB_CHAIN_REACTION_EN
    exp_q.push_back({5'd3, 5'd2});
`endif
    wait_hs("reset_first_blast", 40, n);
    cyc(2);
`ifdef BOMB_CHAIN_REACTION_EN
    chk("chain_valid", bif.blast_valid, 1);
    chk("chain_tile", {bif.blast_tile_x, bif.blast_tile_y}, {5'd3, 5'd2});
`else
    chk("no_chain_valid", bif.blast_valid, 0);
`endif
    chk("pre_rst_expl_on", explosion_on, 1);
    chk("pre_rst_hit", bomberman_hit, 1);
    cyc(1);
    chk("pre_rst_active", active_bombs, 2);
    Reset = 1'b1;
    #1;
    chk("mid_rst_valid", bif.blast_valid, 0);
    chk("mid_rst_bomb_on", bomb_on, 0);
    chk("mid_rst_expl_on", explosion_on, 0);
    chk("mid_rst_hit", bomberman_hit, 0);
    chk("mid_rst_active", active_bombs, 0);
    cyc(2);
    Reset = 1'b0;
    cyc(3);
    chk("post_rst_valid", bif.blast_valid, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
